fp_div_iter: RTL
================

# fp_div_iter

Iterative radix-2 restoring significand divider, one quotient bit per clock. It sits directly upstream of the rounding stage. It takes pre-unpacked, pre-normalized operands plus special-case flags, and produces the `sig/expo/mant/rema/grs/fmt/rm/snan/qnan/dbz/inf/zero` bundle the rounder consumes. Subnormal results are denormalized here, one bit per cycle, so the rounder only ever sees `expo == 0` for subnormals.

## Interface
- No parameters. Widths are fixed for the float (fmt 0) and double (fmt 1) formats.
- `reset` input 1: asynchronous, active-low.
- `clock` input 1: rising-edge clock.
- `in_valid` input 1: operand bundle valid.
- `in_ready` output 1: high only in IDLE.
- `in_sig_a`, `in_sig_b` input 1 each: operand signs.
- `in_expo_a`, `in_expo_b` input 14 each: signed biased exponents. Values may be ≤ 0 for pre-normalized subnormals.
- `in_mant_a`, `in_mant_b` input 53 each: normalized significands. fmt 0 uses bits [23:0] with bit 23 set; fmt 1 uses bits [52:0] with bit 52 set.
- `in_fmt` input 2: 0 = float, 1 = double. Values 2 and 3 use float width and are forwarded unchanged.
- `in_rm` input 3: rounding mode, forwarded unchanged.
- `in_snan`, `in_qnan`, `in_dbz`, `in_inf`, `in_zero` input 1 each: special-case flags decoded upstream.
- `out_valid` output 1: result bundle valid.
- `out_ready` input 1: downstream accepts the result.
- `out_sig` 1, `out_expo` 14, `out_mant` 54, `out_rema` 2, `out_grs` 3, `out_fmt` 2, `out_rm` 3, `out_snan`/`out_qnan`/`out_dbz`/`out_inf`/`out_zero` 1 each: outputs feeding the rounder.

## Operation
- States: IDLE, DIV, NORM, DENORM, DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid`, latch all inputs.
  - `out_sig` = `in_sig_a ^ in_sig_b`; `fmt` and `rm` are forwarded.
  - If any special flag is set, go to DONE with mant, expo, grs and rema all 0 and the flags copied. Otherwise go to DIV.
- Width N = 53 for fmt 1, else N = 24. Iteration counter is loaded with N+2.
- DIV, with A and B the latched significands:
  - Per cycle: partial remainder p = 2p or 2p + A-bit, following standard restoring division of A·2^(N+1) by B.
  - If p ≥ B, then p −= B and the quotient bit is 1; otherwise the bit is 0. The bit shifts into q.
  - After N+2 cycles: q = floor(A·2^(N+1)/B), residual r = p. Go to NORM.
- NORM:
  - If q[N+1] = 1: mant = q[N+1:2], g = q[1], rd = q[0], expo = ea − eb + bias.
  - Else: mant = q[N:1], g = q[0], rd = 0, expo = ea − eb + bias − 1.
  - bias = 1023 for fmt 1, else 127.
  - sticky s = 0; rema = 2'b01 if r ≠ 0, else 2'b00.
  - Go to DENORM if signed expo ≤ 0, else DONE.
- DENORM:
  - Each cycle: {mant, g, rd} >>= 1, s |= shifted-out rd, expo += 1.
  - When expo reaches 1: set expo = 0 and go to DONE.
  - Stop after at most N+2 shifts. Once capped, expo = 0 and all shifted-out bits are ORed into s.
- DONE:
  - `out_valid` = 1; outputs are `out_grs` = {g, rd, s}, `out_rema`, `out_mant`, `out_expo`.
  - On `out_ready` go to IDLE.
- Overflow (expo > 254 or > 2046) is passed through unmodified; the rounder detects it.
- 14-bit signed exponent arithmetic. Intermediate range is guaranteed by upstream: |expo| < 4096.

## Timing
- Reset (asynchronous, `reset` = 0): state = IDLE, `in_ready` = 1 after release, `out_valid` = 0, all data outputs 0.
- Reset mid-operation aborts the divide immediately. Nothing is emitted.
- Acceptance occurs on the edge where `in_valid & in_ready`.
- Normal-result latency: `out_valid` first high N+4 cycles after acceptance (N+2 DIV, 1 NORM, then DONE). That is 28 cycles for fmt 0 and 57 for fmt 1.
- A subnormal result adds k = min(1 − expo_norm, N+2) cycles.
- Special inputs: `out_valid` high 1 cycle after acceptance.
- All outputs are registered and held stable while `out_valid & ~out_ready`.
- `in_ready` = 0 from acceptance until the DONE handshake completes. One operation is in flight at a time; there is no input/output overlap.
- `in_valid` asserted while `in_ready` = 0 is ignored. It has no effect on in-flight state.

## Test plan
- **Float 1.0/1.0:** mant 0x800000, expo 127 for both operands -> after 28 cycles: mant 0x800000, expo 127, grs 0, rema 0, sig 0.
- **Float 1.0/3.0:** a = 0x800000 e127, b = 0xC00000 e128 -> mant 0xAAAAAA, expo 125, grs 3'b100, rema 2'b01.
- **Double 2.0/1.0:** a = 1<<52 e1024, b = 1<<52 e1023 -> mant 1<<52, expo 1024, grs 0; `out_valid` at cycle 57.
- **Float subnormal:** a = 0x800000 e1, b = 0x800000 e129 -> 2 extra cycles; mant 0x200000, expo 0, grs 0, rema 0.
- **Special:** `in_dbz` = 1, sig_a = 1, sig_b = 0 -> `out_valid` 1 cycle after acceptance; out_dbz = 1, out_sig = 1, mant 0. Then `out_ready` held 0 for 5 cycles -> outputs stable and `in_ready` = 0 throughout.
- **Reset abort:** reset asserted at DIV cycle 10 -> `out_valid` = 0 and outputs 0 immediately. After release, a new operation completes with correct values and normal latency.

Source files
------------

// File: rtl/fp_div_iter_if.sv
// Handshake and data bundle between the operand unpacker, the iterative
// divider and the rounder.
interface fp_div_iter_if;
  logic               in_valid;
  logic               in_ready;
  logic               in_sig_a;
  logic               in_sig_b;
  logic signed [13:0] in_expo_a;
  logic signed [13:0] in_expo_b;
  logic [52:0]        in_mant_a;
  logic [52:0]        in_mant_b;
  logic [1:0]         in_fmt;
  logic [2:0]         in_rm;
  logic               in_snan;
  logic               in_qnan;
  logic               in_dbz;
  logic               in_inf;
  logic               in_zero;
  logic               out_valid;
  logic               out_ready;
  logic               out_sig;
  logic signed [13:0] out_expo;
  logic [53:0]        out_mant;
  logic [1:0]         out_rema;
  logic [2:0]         out_grs;
  logic [1:0]         out_fmt;
  logic [2:0]         out_rm;
  logic               out_snan;
  logic               out_qnan;
  logic               out_dbz;
  logic               out_inf;
  logic               out_zero;

  modport master (
    output in_valid, in_sig_a, in_sig_b, in_expo_a, in_expo_b, in_mant_a, in_mant_b,
           in_fmt, in_rm, in_snan, in_qnan, in_dbz, in_inf, in_zero, out_ready,
    input  in_ready, out_valid, out_sig, out_expo, out_mant, out_rema, out_grs,
           out_fmt, out_rm, out_snan, out_qnan, out_dbz, out_inf, out_zero
  );

  modport slave (
    input  in_valid, in_sig_a, in_sig_b, in_expo_a, in_expo_b, in_mant_a, in_mant_b,
           in_fmt, in_rm, in_snan, in_qnan, in_dbz, in_inf, in_zero, out_ready,
    output in_ready, out_valid, out_sig, out_expo, out_mant, out_rema, out_grs,
           out_fmt, out_rm, out_snan, out_qnan, out_dbz, out_inf, out_zero
  );
endinterface

// File: rtl/fp_div_iter.sv
// Iterative radix-2 restoring significand divider (one quotient bit per
// clock) with normalization and bit-serial denormalization of subnormal
// results, feeding the rounder.
module fp_div_iter (
  input  logic         clock,
  input  logic         reset,
  fp_div_iter_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_DIV, S_NORM, S_DENORM, S_DONE} state_t;

  state_t             r_state, w_next;
  logic [54:0]        r_p, r_q;
  logic [52:0]        r_b;
  logic [5:0]         r_cnt;
  logic signed [13:0] r_expo;
  logic [53:0]        r_mant;
  logic               r_g, r_rd, r_s;
  logic [1:0]         r_rema, r_fmt;
  logic [2:0]         r_rm;
  logic               r_sig, r_snan, r_qnan, r_dbz, r_inf, r_zero;

  logic               w_in_dbl, w_dbl, w_special, w_ge, w_top, w_den_end;
  logic [52:0]        w_mask, w_ma, w_mb;
  logic [5:0]         w_len_in, w_len;
  logic signed [13:0] w_bias_in, w_expo_norm, w_expo_inc;
  logic [54:0]        w_diff;

  assign w_in_dbl    = (bus.in_fmt == 2'd1);
  assign w_dbl       = (r_fmt == 2'd1);
  assign w_mask      = w_in_dbl ? {53{1'b1}} : {29'd0, {24{1'b1}}};
  assign w_ma        = bus.in_mant_a & w_mask;
  assign w_mb        = bus.in_mant_b & w_mask;
  // N+2 quotient bits are developed; the same count caps the denormalizer
  assign w_len_in    = w_in_dbl ? 6'd55 : 6'd26;
  assign w_len       = w_dbl ? 6'd55 : 6'd26;
  assign w_bias_in   = w_in_dbl ? 14'sd1023 : 14'sd127;
  assign w_special   = bus.in_snan | bus.in_qnan | bus.in_dbz | bus.in_inf | bus.in_zero;
  // Partial remainder stays below 2B, so 55 bits never overflow
  assign w_ge        = (r_p >= {2'b00, r_b});
  assign w_diff      = r_p - {2'b00, r_b};
  // Quotient lies in (2^N, 2^(N+2)); its MSB position picks the normalization
  assign w_top       = w_dbl ? r_q[54] : r_q[25];
  assign w_expo_norm = w_top ? r_expo : r_expo - 14'sd1;
  assign w_expo_inc  = r_expo + 14'sd1;
  assign w_den_end   = (w_expo_inc == 14'sd1) || (r_cnt == 6'd1);

  // State register; reset aborts any divide in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode and handshake outputs
  always_comb begin
    w_next        = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) w_next = w_special ? S_DONE : S_DIV;
      end
      S_DIV:    if (r_cnt == 6'd1) w_next = S_NORM;
      S_NORM:   w_next = (w_expo_norm <= 14'sd0) ? S_DENORM : S_DONE;
      S_DENORM: if (w_den_end) w_next = S_DONE;
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // Operand capture, quotient iteration, normalization and denormal shifting
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_p    <= '0;  r_q    <= '0;  r_b   <= '0;  r_cnt <= '0;
      r_expo <= '0;  r_mant <= '0;  r_g   <= 1'b0; r_rd <= 1'b0; r_s <= 1'b0;
      r_rema <= '0;  r_fmt  <= '0;  r_rm  <= '0;  r_sig <= 1'b0;
      r_snan <= 1'b0; r_qnan <= 1'b0; r_dbz <= 1'b0; r_inf <= 1'b0; r_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.in_valid) begin
          r_sig  <= bus.in_sig_a ^ bus.in_sig_b;
          r_fmt  <= bus.in_fmt;
          r_rm   <= bus.in_rm;
          r_snan <= bus.in_snan;
          r_qnan <= bus.in_qnan;
          r_dbz  <= bus.in_dbz;
          r_inf  <= bus.in_inf;
          r_zero <= bus.in_zero;
          r_mant <= '0;
          r_g    <= 1'b0;
          r_rd   <= 1'b0;
          r_s    <= 1'b0;
          r_rema <= '0;
          r_q    <= '0;
          r_p    <= {2'b00, w_ma};
          r_b    <= w_mb;
          r_cnt  <= w_len_in;
          r_expo <= w_special ? 14'sd0 : bus.in_expo_a - bus.in_expo_b + w_bias_in;
        end
        S_DIV: begin
          r_p   <= (w_ge ? w_diff : r_p) << 1;
          r_q   <= {r_q[53:0], w_ge};
          r_cnt <= r_cnt - 6'd1;
        end
        S_NORM: begin
          r_mant <= w_top ? {1'b0, r_q[54:2]} : r_q[54:1];
          r_g    <= w_top ? r_q[1] : r_q[0];
          r_rd   <= w_top ? r_q[0] : 1'b0;
          r_s    <= 1'b0;
          r_rema <= {1'b0, |r_p};
          r_expo <= w_expo_norm;
          r_cnt  <= w_len;
        end
        S_DENORM: begin
          r_mant <= r_mant >> 1;
          r_g    <= r_mant[0];
          r_rd   <= r_g;
          r_s    <= r_s | r_rd;
          r_cnt  <= r_cnt - 6'd1;
          r_expo <= w_den_end ? 14'sd0 : w_expo_inc;
        end
        default: ;
      endcase
    end
  end

  assign bus.out_sig  = r_sig;
  assign bus.out_expo = r_expo;
  assign bus.out_mant = r_mant;
  assign bus.out_rema = r_rema;
  assign bus.out_grs  = {r_g, r_rd, r_s};
  assign bus.out_fmt  = r_fmt;
  assign bus.out_rm   = r_rm;
  assign bus.out_snan = r_snan;
  assign bus.out_qnan = r_qnan;
  assign bus.out_dbz  = r_dbz;
  assign bus.out_inf  = r_inf;
  assign bus.out_zero = r_zero;
endmodule
